// File: rtl/plru_pkg.sv
// Shared sizing helpers and tree-navigation functions for the PLRU replacer.
package plru_pkg;

    function automatic int set_width(input int sets);
        return (sets > 1) ? $clog2(sets) : 1;
    endfunction

    // A single-way set has no tree; keep one dummy bit so vectors stay legal.
    function automatic int node_count(input int ways);
        return (ways > 1) ? ways - 1 : 1;
    endfunction

    function automatic int child_node(input int node, input logic dir);
        return 2 * node + 1 + int'(dir);
    endfunction

endpackage

// File: rtl/plru_tree_core.sv
// Combinational PLRU tree: victim selection plus one touch update.
module plru_tree_core
    import plru_pkg::*;
#(
    parameter int WAY_COUNT = 4,
    localparam int NodeW = node_count(WAY_COUNT)
) (
    input  logic [NodeW-1:0]     tree,
    input  logic [WAY_COUNT-1:0] touch,
    input  logic                 self_touch,
    input  logic [WAY_COUNT-1:0] invalid,
    input  logic [WAY_COUNT-1:0] lock,
    output logic [NodeW-1:0]     tree_next,
    output logic [WAY_COUNT-1:0] victim,
    output logic                 none
);
    localparam int Levels = $clog2(WAY_COUNT);

    logic [WAY_COUNT-1:0] free;
    logic [WAY_COUNT-1:0] sel;
    logic [NodeW-1:0]     sh;
    logic                 dir;
    logic                 l_all;
    logic                 r_all;
    logic                 tb;
    int                   base;
    int                   half;
    int                   node;
    int                   tw;
    int                   tnode;

    always_comb begin
        free   = invalid & ~lock;
        none   = &lock;
        victim = '0;
        base   = 0;
        half   = 0;
        node   = 0;
        sh     = '0;
        dir    = 1'b0;
        l_all  = 1'b1;
        r_all  = 1'b1;
        if (|free) begin
            victim = free & (~free + WAY_COUNT'(1));
        end else if (!none) begin
            // Steer away from a fully locked half; both halves cannot be locked here.
            for (int l = 0; l < Levels; l++) begin
                half  = (WAY_COUNT >> l) / 2;
                l_all = 1'b1;
                r_all = 1'b1;
                for (int i = 0; i < WAY_COUNT; i++) begin
                    if (i >= base && i < base + half && !lock[i])
                        l_all = 1'b0;
                    if (i >= base + half && i < base + 2 * half && !lock[i])
                        r_all = 1'b0;
                end
                sh  = tree >> node;
                dir = sh[0];
                if (l_all)
                    dir = 1'b1;
                else if (r_all)
                    dir = 1'b0;
                if (dir)
                    base = base + half;
                node = child_node(node, dir);
            end
            victim = WAY_COUNT'(1) << base;
        end
    end

    always_comb begin
        sel       = self_touch ? victim : touch;
        sel       = sel & (~sel + WAY_COUNT'(1));
        tree_next = tree;
        tw        = 0;
        tnode     = 0;
        tb        = 1'b0;
        for (int i = 0; i < WAY_COUNT; i++)
            if (sel[i])
                tw = i;
        if (|sel) begin
            for (int l = 0; l < Levels; l++) begin
                tb        = ((tw >> (Levels - 1 - l)) & 1) != 0;
                tree_next = (tree_next & ~(NodeW'(1) << tnode))
                          | (NodeW'(!tb) << tnode);
                tnode     = child_node(tnode, tb);
            end
        end
    end

endmodule

// File: rtl/plru_replacer.sv
// Multi-set tree-PLRU victim selector with invalid-first, lock-aware picks
// and a one-deep registered response behind a valid/ready handshake.
module plru_replacer
    import plru_pkg::*;
#(
    parameter int SET_COUNT  = 4,
    parameter int WAY_COUNT  = 4,
    parameter bit AUTO_TOUCH = 1'b1,
    localparam int SetW  = set_width(SET_COUNT),
    localparam int NodeW = node_count(WAY_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 touch_valid_i,
    input  logic [SetW-1:0]      touch_set_i,
    input  logic [WAY_COUNT-1:0] touch_way_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [SetW-1:0]      req_set_i,
    input  logic [WAY_COUNT-1:0] req_invalid_i,
    input  logic [WAY_COUNT-1:0] req_lock_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [WAY_COUNT-1:0] resp_way_o,
    output logic                 resp_none_o
);
    logic [NodeW-1:0]     tree_q [SET_COUNT];
    logic [NodeW-1:0]     touch_tree;
    logic [NodeW-1:0]     req_tree;
    logic [NodeW-1:0]     t_next;
    logic [NodeW-1:0]     a_next;
    logic [NodeW-1:0]     b_next;
    logic [WAY_COUNT-1:0] a_touch;
    logic [WAY_COUNT-1:0] t_victim;
    logic [WAY_COUNT-1:0] a_victim;
    logic [WAY_COUNT-1:0] b_victim;
    logic                 t_none;
    logic                 a_none;
    logic                 b_none;
    logic                 touch_in;
    logic                 req_in;
    logic                 accept;
    logic                 unused;

    assign touch_in    = touch_valid_i && (int'(touch_set_i) < SET_COUNT);
    assign req_in      = int'(req_set_i) < SET_COUNT;
    assign req_ready_o = !resp_valid_o || resp_ready_i;
    assign accept      = req_valid_i && req_ready_o;
    assign touch_tree  = touch_in ? tree_q[touch_set_i] : '0;
    assign req_tree    = req_in ? tree_q[req_set_i] : '0;
    assign a_touch     = (touch_in && touch_set_i == req_set_i)
                       ? touch_way_i : '0;
    assign unused      = ^{t_victim, t_none, a_victim, a_none};

    // Touch-set update, used alone when the touch hits a non-requested set.
    plru_tree_core #(.WAY_COUNT(WAY_COUNT)) u_touch (
        .tree       (touch_tree),
        .touch      (touch_way_i),
        .self_touch (1'b0),
        .invalid    ('0),
        .lock       ('0),
        .tree_next  (t_next),
        .victim     (t_victim),
        .none       (t_none)
    );

    // Request set: external touch first, then victim pick on the bypassed state.
    plru_tree_core #(.WAY_COUNT(WAY_COUNT)) u_req_touch (
        .tree       (req_tree),
        .touch      (a_touch),
        .self_touch (1'b0),
        .invalid    ('0),
        .lock       ('0),
        .tree_next  (a_next),
        .victim     (a_victim),
        .none       (a_none)
    );

    plru_tree_core #(.WAY_COUNT(WAY_COUNT)) u_req_pick (
        .tree       (a_next),
        .touch      ('0),
        .self_touch (AUTO_TOUCH),
        .invalid    (req_invalid_i),
        .lock       (req_lock_i),
        .tree_next  (b_next),
        .victim     (b_victim),
        .none       (b_none)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SET_COUNT; s++)
                tree_q[s] <= '0;
            resp_valid_o <= 1'b0;
            resp_way_o   <= '0;
            resp_none_o  <= 1'b0;
        end else begin
            for (int s = 0; s < SET_COUNT; s++) begin
                if (touch_in && int'(touch_set_i) == s)
                    tree_q[s] <= t_next;
                if (accept && req_in && int'(req_set_i) == s)
                    tree_q[s] <= b_next;
            end
            if (accept) begin
                resp_valid_o <= 1'b1;
                resp_way_o   <= req_in ? b_victim : '0;
                resp_none_o  <= req_in ? b_none : 1'b1;
            end else if (resp_ready_i) begin
                resp_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_plru_replacer.sv
// Bench for plru_replacer: directed table, handshake/reset sequences and a
// randomized run against a recency-timestamp PLRU model (two AUTO_TOUCH configs).
module tb_plru_replacer;

    logic       clk = 1'b0;
    logic       rst;
    logic       touch_valid;
    logic [1:0] touch_set;
    logic [3:0] touch_way;
    logic       req_valid;
    logic [1:0] req_set;
    logic [3:0] req_invalid;
    logic [3:0] req_lock;
    logic       resp_ready;
    logic       rdy   [2];
    logic       rval  [2];
    logic [3:0] rway  [2];
    logic       rnone [2];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    plru_replacer #(.SET_COUNT(4), .WAY_COUNT(4), .AUTO_TOUCH(1'b1)) u_auto (
        .clk           (clk),
        .rst           (rst),
        .touch_valid_i (touch_valid),
        .touch_set_i   (touch_set),
        .touch_way_i   (touch_way),
        .req_valid_i   (req_valid),
        .req_ready_o   (rdy[0]),
        .req_set_i     (req_set),
        .req_invalid_i (req_invalid),
        .req_lock_i    (req_lock),
        .resp_valid_o  (rval[0]),
        .resp_ready_i  (resp_ready),
        .resp_way_o    (rway[0]),
        .resp_none_o   (rnone[0])
    );

    plru_replacer #(.SET_COUNT(4), .WAY_COUNT(4), .AUTO_TOUCH(1'b0)) u_plain (
        .clk           (clk),
        .rst           (rst),
        .touch_valid_i (touch_valid),
        .touch_set_i   (touch_set),
        .touch_way_i   (touch_way),
        .req_valid_i   (req_valid),
        .req_ready_o   (rdy[1]),
        .req_set_i     (req_set),
        .req_invalid_i (req_invalid),
        .req_lock_i    (req_lock),
        .resp_valid_o  (rval[1]),
        .resp_ready_i  (resp_ready),
        .resp_way_o    (rway[1]),
        .resp_none_o   (rnone[1])
    );

    // Model: last-touch timestamp per way; a node points away from the
    // most recently touched way beneath it (left if never touched).
    int unsigned stamp [2][4][4];
    int unsigned tick;
    bit          m_valid [2];
    logic [3:0]  m_way   [2];
    bit          m_none  [2];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 4; s++)
                for (int w = 0; w < 4; w++)
                    stamp[d][s][w] = 0;
            m_valid[d] = 1'b0;
            m_way[d]   = 4'b0;
            m_none[d]  = 1'b0;
        end
        tick = 0;
    endfunction

    function automatic void model_touch(int d, int s, logic [3:0] w);
        int idx = -1;
        for (int i = 3; i >= 0; i--)
            if (w[i]) idx = i;
        if (idx >= 0) begin
            tick++;
            stamp[d][s][idx] = tick;
        end
    endfunction

    function automatic int model_victim(int d, int s, logic [3:0] inv,
                                        logic [3:0] lock);
        int lo = 0;
        int hi = 4;
        int res = -1;
        for (int i = 3; i >= 0; i--)
            if (inv[i] && !lock[i]) res = i;
        if (res < 0 && lock != 4'hf) begin
            while (hi - lo > 1) begin
                int mid = (lo + hi) / 2;
                int m = -1;
                int unsigned best = 0;
                bit right;
                bit l_all = 1'b1;
                bit r_all = 1'b1;
                for (int i = lo; i < hi; i++)
                    if (stamp[d][s][i] > best) begin
                        best = stamp[d][s][i];
                        m = i;
                    end
                right = (m >= 0) && (m < mid);
                for (int i = lo; i < hi; i++)
                    if (!lock[i]) begin
                        if (i < mid) l_all = 1'b0;
                        else r_all = 1'b0;
                    end
                if (!right && l_all) right = 1'b1;
                else if (right && r_all) right = 1'b0;
                if (right) lo = mid;
                else hi = mid;
            end
            res = lo;
        end
        return res;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        touch_valid = 1'b0;
        touch_set   = 2'd0;
        touch_way   = 4'b0;
        req_valid   = 1'b0;
        req_set     = 2'd0;
        req_invalid = 4'b0;
        req_lock    = 4'b0;
        resp_ready  = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic       tv;
        logic [1:0] ts;
        logic [3:0] tw;
        logic       rv;
        logic [1:0] rs;
        logic [3:0] inv;
        logic [3:0] lock;
        logic [3:0] way_a;
        logic [3:0] way_b;
        logic       none;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(logic tv, logic [1:0] ts, logic [3:0] tw,
                                logic rv, logic [1:0] rs, logic [3:0] inv,
                                logic [3:0] lock, logic [3:0] wa,
                                logic [3:0] wb, logic none);
        vec_t v;
        v.tv = tv; v.ts = ts; v.tw = tw;
        v.rv = rv; v.rs = rs; v.inv = inv; v.lock = lock;
        v.way_a = wa; v.way_b = wb; v.none = none;
        return v;
    endfunction

    initial begin
        int v;
        bit acc;
        vecs[0] = mk(0, 0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 0);
        vecs[1] = mk(0, 0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0001, 0);
        vecs[2] = mk(1, 1, 4'b0001, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        vecs[3] = mk(0, 0, 4'b0000, 1, 1, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 0);
        vecs[4] = mk(1, 1, 4'b0100, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        vecs[5] = mk(0, 0, 4'b0000, 1, 1, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 0);
        vecs[6] = mk(0, 0, 4'b0000, 1, 2, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 0);
        vecs[7] = mk(0, 0, 4'b0000, 1, 2, 4'b0000, 4'b0001, 4'b0010, 4'b0010, 0);
        vecs[8] = mk(0, 0, 4'b0000, 1, 2, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1);
        vecs[9] = mk(1, 3, 4'b0001, 1, 3, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 0);

        do_reset();
        for (int d = 0; d < 2; d++) begin
            chk("reset_valid", 32'(rval[d]), 0);
            chk("reset_way", 32'(rway[d]), 0);
            chk("reset_none", 32'(rnone[d]), 0);
            chk("reset_ready", 32'(rdy[d]), 1);
        end

        for (int k = 0; k < 10; k++) begin
            idle();
            touch_valid = vecs[k].tv;
            touch_set   = vecs[k].ts;
            touch_way   = vecs[k].tw;
            req_valid   = vecs[k].rv;
            req_set     = vecs[k].rs;
            req_invalid = vecs[k].inv;
            req_lock    = vecs[k].lock;
            @(posedge clk);
            #1;
            if (vecs[k].rv) begin
                chk("tbl_valid", 32'(rval[0]), 1);
                chk("tbl_way_auto", 32'(rway[0]), 32'(vecs[k].way_a));
                chk("tbl_way_plain", 32'(rway[1]), 32'(vecs[k].way_b));
                chk("tbl_none_auto", 32'(rnone[0]), 32'(vecs[k].none));
                chk("tbl_none_plain", 32'(rnone[1]), 32'(vecs[k].none));
            end
        end

        // Held response must not move while the consumer stalls.
        do_reset();
        req_valid  = 1'b1;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("hold_valid", 32'(rval[d]), 1);
            chk("hold_way0", 32'(rway[d]), 32'b0001);
        end
        touch_valid = 1'b1;
        touch_set   = 2'd0;
        touch_way   = 4'b0001;
        req_lock    = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #1;
            for (int d = 0; d < 2; d++)
                chk("hold_ready_low", 32'(rdy[d]), 0);
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                chk("hold_valid_kept", 32'(rval[d]), 1);
                chk("hold_way_kept", 32'(rway[d]), 32'b0001);
            end
        end
        idle();
        #1;
        for (int d = 0; d < 2; d++)
            chk("hold_release_ready", 32'(rdy[d]), 1);
        @(posedge clk);
        #1;

        // Reset while a response is held drops it and clears every set.
        req_valid  = 1'b1;
        req_set    = 2'd1;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_hold_valid", 32'(rval[d]), 0);
            chk("rst_hold_way", 32'(rway[d]), 0);
        end
        rst = 1'b0;
        idle();
        for (int s = 0; s < 4; s++) begin
            req_valid = 1'b1;
            req_set   = 2'(s);
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++)
                chk("rst_set_victim", 32'(rway[d]), 32'b0001);
        end

        // Randomized traffic against the timestamp model.
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            touch_valid = 1'($urandom % 2);
            touch_set   = 2'($urandom % 4);
            touch_way   = ($urandom % 4 == 0) ? 4'($urandom)
                                              : 4'(1 << ($urandom % 4));
            req_valid   = ($urandom % 3) != 0;
            req_set     = 2'($urandom % 4);
            req_invalid = ($urandom % 3 == 0) ? 4'($urandom) : 4'b0;
            req_lock    = ($urandom % 4 == 0) ? 4'($urandom) : 4'b0;
            resp_ready  = ($urandom % 4) != 0;
            #1;
            for (int d = 0; d < 2; d++)
                chk("rnd_ready", 32'(rdy[d]),
                    32'(!m_valid[d] || resp_ready));
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                acc = req_valid && (!m_valid[d] || resp_ready);
                if (touch_valid)
                    model_touch(d, int'(touch_set), touch_way);
                if (acc) begin
                    v = model_victim(d, int'(req_set), req_invalid, req_lock);
                    m_valid[d] = 1'b1;
                    m_none[d]  = (v < 0);
                    m_way[d]   = (v < 0) ? 4'b0 : 4'(1 << v);
                    if (d == 0 && v >= 0)
                        model_touch(d, int'(req_set), m_way[d]);
                end else if (resp_ready) begin
                    m_valid[d] = 1'b0;
                end
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                chk("rnd_valid", 32'(rval[d]), 32'(m_valid[d]));
                if (m_valid[d]) begin
                    chk("rnd_way", 32'(rway[d]), 32'(m_way[d]));
                    chk("rnd_none", 32'(rnone[d]), 32'(m_none[d]));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
